// File: rtl/pfd_charge_pump.sv
// Clocked tri-state phase-frequency detector with a real-valued charge-pump
// drive. Rising edges of ref_in/fb_in are found by oversampling on clk. The
// detector reports a signed phase error per comparison and a lock flag. CP is
// a current-source drive of the loop-filter node: '{V, I, R}.
module pfd_charge_pump #(
  parameter real icp      = 100e-6,
  parameter real ileak    = 0.0,
  parameter real rmax     = 1e15,
  parameter int  CW       = 12,
  parameter int  DZ       = 2,
  parameter int  LOCK_WIN = 2,
  parameter int  LOCK_N   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ref_in,
  input  logic                 fb_in,
  output real                  CP [3],
  output logic                 up,
  output logic                 dn,
  output logic signed [CW:0]   phase_err,
  output logic                 err_valid,
  output logic                 locked
);

  localparam int LW = $clog2(LOCK_N + 1);
  localparam int DW = (DZ > 1) ? $clog2(DZ) : 1;
  localparam logic [CW-1:0] WMAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN, S_RST} state_e;

  state_e                state_q, state_d;
  logic                  ref_q, fb_q;
  logic [CW-1:0]         width_q, width_d;
  logic [DW-1:0]         dz_q, dz_d;
  logic                  pend_ref_q, pend_ref_d;
  logic                  pend_fb_q, pend_fb_d;
  logic signed [CW:0]    phase_err_q, phase_err_d;
  logic                  err_valid_q, err_valid_d;
  logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
  logic                  locked_q, locked_d;

  logic                  ref_edge, fb_edge;
  logic                  ref_ev, fb_ev;
  logic                  done;
  logic                  done_neg;
  logic [CW-1:0]         done_width;
  logic signed [CW:0]    done_ext;

  // A new sample high while the previous sample was low is a rising edge.
  assign ref_edge = ref_in & ~ref_q;
  assign fb_edge  = fb_in & ~fb_q;

  // Next-state, width counting, pending capture, and comparison completion.
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    dz_d        = dz_q;
    pend_ref_d  = pend_ref_q;
    pend_fb_d   = pend_fb_q;
    phase_err_d = phase_err_q;
    err_valid_d = 1'b0;
    lock_cnt_d  = lock_cnt_q;
    locked_d    = locked_q;
    ref_ev      = 1'b0;
    fb_ev       = 1'b0;
    done        = 1'b0;
    done_neg    = 1'b0;
    done_width  = '0;
    done_ext    = '0;

    if (!en) begin
      // Disabled: drop any pulse in flight, keep the measurement history.
      state_d    = S_IDLE;
      width_d    = '0;
      dz_d       = '0;
      pend_ref_d = 1'b0;
      pend_fb_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Edges that arrived during the reset pulse are replayed here.
          ref_ev     = ref_edge | pend_ref_q;
          fb_ev      = fb_edge | pend_fb_q;
          pend_ref_d = 1'b0;
          pend_fb_d  = 1'b0;
          if (ref_ev && fb_ev) begin
            done       = 1'b1;
            done_width = '0;
          end else if (ref_ev) begin
            state_d = S_UP;
            width_d = {{(CW-1){1'b0}}, 1'b1};
          end else if (fb_ev) begin
            state_d = S_DN;
            width_d = {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_UP: begin
          if (fb_edge) begin
            done       = 1'b1;
            done_width = width_q;
            state_d    = S_RST;
            dz_d       = '0;
            width_d    = '0;
          end else if (width_q != WMAX) begin
            // Further ref edges just keep counting: frequency detection.
            width_d = width_q + 1'b1;
          end
        end
        S_DN: begin
          if (ref_edge) begin
            done       = 1'b1;
            done_neg   = 1'b1;
            done_width = width_q;
            state_d    = S_RST;
            dz_d       = '0;
            width_d    = '0;
          end else if (width_q != WMAX) begin
            width_d = width_q + 1'b1;
          end
        end
        S_RST: begin
          pend_ref_d = pend_ref_q | ref_edge;
          pend_fb_d  = pend_fb_q | fb_edge;
          if (dz_q == DW'(DZ - 1)) begin
            state_d = S_IDLE;
            dz_d    = '0;
          end else begin
            dz_d = dz_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (done) begin
      done_ext    = {1'b0, done_width};
      phase_err_d = done_neg ? -done_ext : done_ext;
      err_valid_d = 1'b1;
      if (int'(done_width) <= LOCK_WIN) begin
        lock_cnt_d = (lock_cnt_q == LW'(LOCK_N)) ? lock_cnt_q : lock_cnt_q + 1'b1;
      end else begin
        lock_cnt_d = '0;
      end
      locked_d = (lock_cnt_d == LW'(LOCK_N));
    end
  end

  // State and edge-history registers; inputs are captured at reset so a
  // level already high at release is not mistaken for an edge.
  always_ff @(posedge clk) begin
    ref_q <= ref_in;
    fb_q  <= fb_in;
    if (rst) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      dz_q        <= '0;
      pend_ref_q  <= 1'b0;
      pend_fb_q   <= 1'b0;
      phase_err_q <= '0;
      err_valid_q <= 1'b0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      dz_q        <= dz_d;
      pend_ref_q  <= pend_ref_d;
      pend_fb_q   <= pend_fb_d;
      phase_err_q <= phase_err_d;
      err_valid_q <= err_valid_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
    end
  end

  // Pump pulses are pure decodes of the state register.
  assign up        = (state_q == S_UP) || (state_q == S_RST);
  assign dn        = (state_q == S_DN) || (state_q == S_RST);
  assign phase_err = phase_err_q;
  assign err_valid = err_valid_q;
  assign locked    = locked_q;

  // Pump current follows up/dn with no extra delay; leakage always present.
  always_comb begin
    CP[0] = 0.0;
    CP[1] = ileak + ((up && !dn) ? icp : ((dn && !up) ? -icp : 0.0));
    CP[2] = rmax;
  end

endmodule

// File: tb/tb_pfd_charge_pump.sv
// Directed bench for pfd_charge_pump (CW=4 so width saturation is reachable).
module tb_pfd_charge_pump;
  localparam int  CW  = 4;
  localparam real ICP = 100e-6;

  logic clk = 1'b0;
  logic rst, en, ref_in, fb_in;
  real  cp [3];
  logic up, dn, err_valid, locked;
  logic signed [CW:0] phase_err;

  int checks = 0;
  int errors = 0;

  pfd_charge_pump #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .CP(cp), .up(up), .dn(dn), .phase_err(phase_err),
    .err_valid(err_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulses on the inputs; returns just after the detecting edge.
  task automatic pulse(input logic r, input logic f);
    ref_in = r;
    fb_in  = f;
    tick();
    ref_in = 1'b0;
    fb_in  = 1'b0;
  endtask

  // Ref leads fb by w cycles (w=0: coincident edges).
  task automatic do_cmp(input int w);
    if (w == 0) begin
      pulse(1'b1, 1'b1);
    end else begin
      pulse(1'b1, 1'b0);
      repeat (w - 1) tick();
      pulse(1'b0, 1'b1);
    end
  endtask

  function automatic real absr(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
    tick(); tick();
    checks++; if (up !== 1'b0 || dn !== 1'b0) begin errors++; $display("FAIL reset_updn: up=%b dn=%b want 0 0", up, dn); end
    checks++; if (phase_err !== 5'sd0) begin errors++; $display("FAIL reset_phase_err: got %0d want 0", phase_err); end
    checks++; if (err_valid !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL reset_flags: err_valid=%b locked=%b want 0 0", err_valid, locked); end
    checks++; if (absr(cp[1]) > 1e-12 || cp[0] != 0.0 || cp[2] != 1e15) begin errors++; $display("FAIL reset_cp: got V=%g I=%g R=%g want 0 0 1e15", cp[0], cp[1], cp[2]); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_up_pulse();
    pulse(1'b1, 1'b0);
    checks++; if (up !== 1'b1 || dn !== 1'b0) begin errors++; $display("FAIL up_start: up=%b dn=%b want 1 0", up, dn); end
    checks++; if (absr(cp[1] - ICP) > 1e-12) begin errors++; $display("FAIL up_current: got %g want %g", cp[1], ICP); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (up !== 1'b1 || dn !== 1'b0) begin errors++; $display("FAIL up_hold%0d: up=%b dn=%b want 1 0", i, up, dn); end
    end
    pulse(1'b0, 1'b1);
    checks++; if (up !== 1'b1 || dn !== 1'b1) begin errors++; $display("FAIL up_rst_pulse: up=%b dn=%b want 1 1", up, dn); end
    checks++; if (err_valid !== 1'b1 || phase_err !== 5'sd5) begin errors++; $display("FAIL up_complete: err_valid=%b phase_err=%0d want 1 5", err_valid, phase_err); end
    checks++; if (absr(cp[1]) > 1e-12) begin errors++; $display("FAIL rst_current: got %g want 0", cp[1]); end
    tick();
    checks++; if (up !== 1'b1 || dn !== 1'b1 || err_valid !== 1'b0) begin errors++; $display("FAIL up_rst_second: up=%b dn=%b ev=%b want 1 1 0", up, dn, err_valid); end
    tick();
    checks++; if (up !== 1'b0 || dn !== 1'b0) begin errors++; $display("FAIL up_idle: up=%b dn=%b want 0 0", up, dn); end
  endtask

  task automatic test_dn_pulse();
    pulse(1'b0, 1'b1);
    checks++; if (up !== 1'b0 || dn !== 1'b1) begin errors++; $display("FAIL dn_start: up=%b dn=%b want 0 1", up, dn); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (absr(cp[1] + ICP) > 1e-12) begin errors++; $display("FAIL dn_current%0d: got %g want %g", i, cp[1], -ICP); end
      if (i < 2) tick();
    end
    pulse(1'b1, 1'b0);
    checks++; if (err_valid !== 1'b1 || phase_err !== -5'sd3) begin errors++; $display("FAIL dn_complete: err_valid=%b phase_err=%0d want 1 -3", err_valid, phase_err); end
    tick(); tick();
    checks++; if (up !== 1'b0 || dn !== 1'b0) begin errors++; $display("FAIL dn_idle: up=%b dn=%b want 0 0", up, dn); end
  endtask

  task automatic test_same_cycle();
    pulse(1'b1, 1'b1);
    checks++; if (up !== 1'b0 || dn !== 1'b0) begin errors++; $display("FAIL same_updn: up=%b dn=%b want 0 0", up, dn); end
    checks++; if (err_valid !== 1'b1 || phase_err !== 5'sd0) begin errors++; $display("FAIL same_complete: err_valid=%b phase_err=%0d want 1 0", err_valid, phase_err); end
    tick();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL same_strobe: err_valid=%b want 0", err_valid); end
  endtask

  task automatic test_freq_sat();
    pulse(1'b1, 1'b0);
    repeat (3) tick();
    pulse(1'b1, 1'b0);
    checks++; if (up !== 1'b1 || dn !== 1'b0) begin errors++; $display("FAIL freq_second_ref: up=%b dn=%b want 1 0", up, dn); end
    repeat (15) tick();
    pulse(1'b0, 1'b1);
    checks++; if (err_valid !== 1'b1 || phase_err !== 5'sd15) begin errors++; $display("FAIL freq_saturate: err_valid=%b phase_err=%0d want 1 15", err_valid, phase_err); end
    tick(); tick();
  endtask

  task automatic test_pending();
    do_cmp(2);
    checks++; if (phase_err !== 5'sd2) begin errors++; $display("FAIL pend_first: phase_err=%0d want 2", phase_err); end
    pulse(1'b1, 1'b0);
    checks++; if (up !== 1'b1 || dn !== 1'b1) begin errors++; $display("FAIL pend_in_rst: up=%b dn=%b want 1 1", up, dn); end
    tick();
    checks++; if (up !== 1'b0 || dn !== 1'b0) begin errors++; $display("FAIL pend_idle: up=%b dn=%b want 0 0", up, dn); end
    tick();
    checks++; if (up !== 1'b1 || dn !== 1'b0) begin errors++; $display("FAIL pend_replay: up=%b dn=%b want 1 0", up, dn); end
    tick(); tick();
    pulse(1'b0, 1'b1);
    checks++; if (err_valid !== 1'b1 || phase_err !== 5'sd3) begin errors++; $display("FAIL pend_width: err_valid=%b phase_err=%0d want 1 3", err_valid, phase_err); end
    tick(); tick();
  endtask

  task automatic test_lock();
    int w [8] = '{1, 2, 0, 2, 1, 0, 2, 1};
    logic signed [CW:0] exp_err;
    do_cmp(5);
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      do_cmp(w[i]);
      exp_err = (CW+1)'(w[i]);
      checks++; if (err_valid !== 1'b1 || phase_err !== exp_err) begin errors++; $display("FAIL lock_cmp%0d: err_valid=%b phase_err=%0d want 1 %0d", i, err_valid, phase_err, exp_err); end
      checks++; if (locked !== (i == 7)) begin errors++; $display("FAIL lock_state%0d: locked=%b want %b", i, locked, (i == 7)); end
      repeat (2) tick();
    end
    do_cmp(5);
    checks++; if (locked !== 1'b0 || phase_err !== 5'sd5) begin errors++; $display("FAIL lock_lost: locked=%b phase_err=%0d want 0 5", locked, phase_err); end
    repeat (2) tick();
  endtask

  task automatic test_enable();
    for (int i = 0; i < 8; i++) begin
      do_cmp(1);
      repeat (2) tick();
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL en_relock: locked=%b want 1", locked); end
    pulse(1'b1, 1'b0);
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL en_up: up=%b want 1", up); end
    en = 1'b0;
    tick();
    checks++; if (up !== 1'b0 || dn !== 1'b0 || absr(cp[1]) > 1e-12) begin errors++; $display("FAIL en_abort: up=%b dn=%b I=%g want 0 0 0", up, dn, cp[1]); end
    checks++; if (locked !== 1'b1 || phase_err !== 5'sd1) begin errors++; $display("FAIL en_hold: locked=%b phase_err=%0d want 1 1", locked, phase_err); end
    pulse(1'b1, 1'b0);
    checks++; if (up !== 1'b0 || dn !== 1'b0) begin errors++; $display("FAIL en_ignore: up=%b dn=%b want 0 0", up, dn); end
    ref_in = 1'b1;
    tick(); tick();
    en = 1'b1;
    tick();
    checks++; if (up !== 1'b0 || dn !== 1'b0) begin errors++; $display("FAIL en_level_not_edge: up=%b dn=%b want 0 0", up, dn); end
    ref_in = 1'b0;
    tick();
    do_cmp(2);
    checks++; if (phase_err !== 5'sd2 || locked !== 1'b1) begin errors++; $display("FAIL en_resume: phase_err=%0d locked=%b want 2 1", phase_err, locked); end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    pulse(1'b1, 1'b0);
    tick();
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL rstmid_up: up=%b want 1", up); end
    rst = 1'b1;
    tick();
    checks++; if (up !== 1'b0 || dn !== 1'b0 || absr(cp[1]) > 1e-12) begin errors++; $display("FAIL rstmid_abort: up=%b dn=%b I=%g want 0 0 0", up, dn, cp[1]); end
    checks++; if (phase_err !== 5'sd0 || locked !== 1'b0) begin errors++; $display("FAIL rstmid_clear: phase_err=%0d locked=%b want 0 0", phase_err, locked); end
    ref_in = 1'b1; fb_in = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (up !== 1'b0 || dn !== 1'b0 || err_valid !== 1'b0) begin errors++; $display("FAIL rst_release_level: up=%b dn=%b ev=%b want 0 0 0", up, dn, err_valid); end
    tick();
    checks++; if (up !== 1'b0 || dn !== 1'b0 || err_valid !== 1'b0) begin errors++; $display("FAIL rst_release_hold: up=%b dn=%b ev=%b want 0 0 0", up, dn, err_valid); end
    ref_in = 1'b0; fb_in = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_up_pulse();
    test_dn_pulse();
    test_same_cycle();
    test_freq_sat();
    test_pending();
    test_lock();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pfd_charge_pump.md
# pfd_charge_pump

Clocked phase-frequency detector with real-valued charge-pump output for the CDR loop. It compares rising edges of `ref_in` and `fb_in`, oversampled on `clk`, with a tri-state PFD state machine. It drives a signed current onto an EEnet node that feeds the loop-filter capacitor directly downstream. It also reports a per-comparison phase-error count and a lock indication.

## Interface
Parameters:
- `icp`, 100e-6: pump current magnitude (A)
- `ileak`, 0.0: constant leakage current, always added to output (A)
- `rmax`, 1e15: output resistance (current-source drive)
- `CW`, 12: phase-width counter width (bits)
- `DZ`, 2: anti-deadzone reset duration (cycles, ≥1)
- `LOCK_WIN`, 2: max |phase width| counted as "in lock" (cycles)
- `LOCK_N`, 8: consecutive in-lock comparisons required to assert `locked`

Ports:
- `clk`  in  1  oversampling clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  detector enable
- `ref_in`  in  1  reference clock/data edge input
- `fb_in`  in  1  feedback (VCO divided) input
- `CP`  inout  EEnet  pump output node, driven '{0.0, I, rmax}
- `up`  out  1  pump-up pulse
- `dn`  out  1  pump-down pulse
- `phase_err`  out  CW+1 signed  last phase error in cycles (+ = ref leads)
- `err_valid`  out  1  one-cycle strobe, `phase_err` updated
- `locked`  out  1  lock indication

## Operation
- Edge detect: registers `ref_q`/`fb_q`. Edge at clock k = sampled input 1 and register 0. On reset, registers load the current input value, so a high level at reset release is not an edge.
- States: IDLE, UP, DN, RST.
  - IDLE: ref edge only → UP. fb edge only → DN. Both → stay IDLE and complete a comparison with width 0.
  - UP: width counter increments each cycle. fb edge → RST and complete a comparison with +width. Further ref edge → stay UP, counter continues (frequency detection).
  - DN: mirror of UP. Complete with −width.
  - RST: `up`=`dn`=1 for exactly DZ cycles, then IDLE. Edges arriving during RST set pending flags (one per input). On return to IDLE, pending flags are treated as edges in that cycle, then cleared.
- Width = number of cycles `up` (or `dn`) was asserted alone before RST. It saturates at 2^CW−1 and the state is held.
- Completion: `phase_err` ← ±width, sign-extended to CW+1. `err_valid`=1 for one cycle.
- Lock: on each completion, width ≤ LOCK_WIN → `lock_cnt`++ (saturates at LOCK_N), else `lock_cnt`←0. `locked` = (`lock_cnt`==LOCK_N), registered.
- Output current I = ileak + (up&!dn ? +icp : dn&!up ? −icp : 0). Positive I charges the downstream capacitor (raises P voltage).
- `en`=0 (synchronous): state←IDLE, `up`=`dn`=0, pending cleared, edges ignored, edge registers still track inputs. `phase_err`, `lock_cnt`, `locked` hold. I = ileak.

## Timing
- Reset values: state IDLE, `up`=0, `dn`=0, `phase_err`=0, `err_valid`=0, `locked`=0, `lock_cnt`=0, width=0, pending=0, CP driven '{0.0, ileak, rmax}.
- Ref edge detected at clock k → `up`=1 after edge k. fb edge at clock m → state RST after edge m. `up`=`dn`=1 from m through m+DZ. IDLE after edge m+DZ.
- `phase_err`=+(m−k) and `err_valid` asserted after edge m. `locked` updates the same edge.
- CP current changes only on clock edges, aligned with the `up`/`dn` registers (0 latency from them).
- Reset asserted mid-pulse: all state returns to reset values at that edge. Current drops to ileak on that edge.
- `rst` has priority over `en`.

## Test plan
- Ref edge at clk 10, fb at 15 → `up` high after edges 10–14, both high 15–16, IDLE after 17. `phase_err`=+5, `err_valid` one cycle after edge 15. CP.I=+100e-6 during UP, 0 during RST.
- Fb edge at 20, ref at 23 → `phase_err`=−3. CP.I=−100e-6 for 3 cycles. Same-cycle edges → `phase_err`=0, no `up`/`dn` pulse, `err_valid`=1.
- Two ref edges with no fb (frequency error) → `up` stays high; CW=4 → `phase_err` saturates at +15 when fb finally arrives.
- Ref edge during RST (DZ=2) → pending; UP entered on the first IDLE cycle, width counted from there.
- 8 comparisons with width ≤2 → `locked`=1 on the 8th `err_valid`. One width of 5 → `locked`=0 at that completion.
- `rst` or `en`=0 asserted mid-UP → `up`=0 next cycle, CP.I=ileak. `en` deassert holds `phase_err`/`locked`. Input high at reset release → no edge detected.
